multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle MIPS-subset datapath.
// Decodes opcode/funct from the instruction register and sequences the
// datapath through fetch, decode, execute, memory and write-back steps.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   opcode, funct         instr[31:26], instr[5:0]
//   zero                  ALU zero flag (beq outcome)
//   mem_ready             memory completion strobe for the current access
//   mem_req, iord, memwrite, irwrite, pcen            memory / PC / IR controls
//   regdst, memtoreg, regwrite                        register file controls
//   alusrca, alusrcb, pcsrc, alucontrol               ALU and PC source selects
//   illegal               one-cycle pulse in DECODE on an undecodable opcode
//
// Configuration macro: MEM_HANDSHAKE_EN
//   defined   -> mem_ready gates FETCH, MEMRD and MEMWR
//   undefined -> mem_ready ignored; every memory state lasts one cycle
//
// Outputs are decoded from the current state (plus mem_ready/zero for
// irwrite/pcen and opcode for illegal) and forced to 0 while reset is low.

module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  localparam int unsigned OpW  = 6;
  localparam int unsigned AluW = 3;

  localparam logic [OpW-1:0] OpRtype = 6'b000000;
  localparam logic [OpW-1:0] OpLw    = 6'b100011;
  localparam logic [OpW-1:0] OpSw    = 6'b101011;
  localparam logic [OpW-1:0] OpBeq   = 6'b000100;
  localparam logic [OpW-1:0] OpAddi  = 6'b001000;
  localparam logic [OpW-1:0] OpJ     = 6'b000010;

  localparam logic [OpW-1:0] FnAdd = 6'b100000;
  localparam logic [OpW-1:0] FnSub = 6'b100010;
  localparam logic [OpW-1:0] FnAnd = 6'b100100;
  localparam logic [OpW-1:0] FnOr  = 6'b100101;
  localparam logic [OpW-1:0] FnSlt = 6'b101010;

  localparam logic [AluW-1:0] AluAnd = 3'b000;
  localparam logic [AluW-1:0] AluOr  = 3'b001;
  localparam logic [AluW-1:0] AluAdd = 3'b010;
  localparam logic [AluW-1:0] AluSub = 3'b110;
  localparam logic [AluW-1:0] AluSlt = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_e;

  state_e state_q, state_d;
  logic   rdy;

  // Effective memory completion: real strobe or constant 1.
`ifdef MEM_HANDSHAKE_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign rdy              = 1'b1;
  assign unused_mem_ready = mem_ready;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; everything held at 0 during reset.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    illegal    = 1'b0;

    if (reset) begin
      unique case (state_q)
        FETCH: begin
          mem_req    = 1'b1;
          alusrcb    = 2'b01;
          alucontrol = AluAdd;
          irwrite    = rdy;
          pcen       = rdy;
          if (rdy) state_d = DECODE;
        end
        DECODE: begin
          alusrcb    = 2'b11;
          alucontrol = AluAdd;
          case (opcode)
            OpLw, OpSw: state_d = MEMADR;
            OpRtype:    state_d = RTYPEEX;
            OpBeq:      state_d = BEQEX;
            OpAddi:     state_d = ADDIEX;
            OpJ:        state_d = JEX;
            default: begin
              state_d = FETCH;
              illegal = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = AluAdd;
          state_d    = (opcode == OpSw) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (rdy) state_d = MEMWB;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
          state_d  = FETCH;
        end
        MEMWR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = 1'b1;
          if (rdy) state_d = FETCH;
        end
        RTYPEEX: begin
          alusrca = 1'b1;
          case (funct)
            FnAdd:   alucontrol = AluAdd;
            FnSub:   alucontrol = AluSub;
            FnAnd:   alucontrol = AluAnd;
            FnOr:    alucontrol = AluOr;
            FnSlt:   alucontrol = AluSlt;
            default: alucontrol = AluAdd;
          endcase
          state_d = RTYPEWB;
        end
        RTYPEWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
          state_d  = FETCH;
        end
        BEQEX: begin
          alusrca    = 1'b1;
          alucontrol = AluSub;
          pcsrc      = 2'b01;
          pcen       = zero;
          state_d    = FETCH;
        end
        ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = AluAdd;
          state_d    = ADDIWB;
        end
        ADDIWB: begin
          regwrite = 1'b1;
          state_d  = FETCH;
        end
        JEX: begin
          pcsrc   = 2'b10;
          pcen    = 1'b1;
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule
